// File: rtl/i2c_txn_sequencer.sv
// Register-level I2C transaction sequencer: expands one read/write request into
// START/WRITE/RSTART/READ_NACK/STOP commands for the byte-level core.
module i2c_txn_sequencer #(
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic [1:0] err,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_rdata
);
    // state   | meaning
    // IDLE    | waiting for req
    // START   | issue START
    // DEVW    | issue WRITE {dev_addr,0}
    // REG     | issue WRITE reg_addr
    // DATA    | issue WRITE wr_data
    // RSTART  | issue repeated START
    // DEVR    | issue WRITE {dev_addr,1}
    // READ    | issue READ_NACK
    // STOP    | issue STOP
    // WAIT    | command accepted, waiting for response or timeout
    // DONE    | one-cycle completion pulse
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_REG, S_DATA, S_RSTART,
        S_DEVR, S_READ, S_STOP, S_WAIT, S_DONE
    } state_t;

    localparam logic [2:0] CMD_START  = 3'd0;
    localparam logic [2:0] CMD_WRITE  = 3'd1;
    localparam logic [2:0] CMD_READ   = 3'd2;
    localparam logic [2:0] CMD_STOP   = 3'd3;
    localparam logic [2:0] CMD_RSTART = 3'd4;

    // Counter compares against the last count so TO_W bits always suffice.
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

    state_t          state;
    state_t          cur;
    logic            rw_q;
    logic [6:0]      dev_q;
    logic [7:0]      reg_q;
    logic [7:0]      wd_q;
    logic [2:0]      retry;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      err_lat;
    logic [2:0]      nxt_cmd;
    logic [7:0]      nxt_wdata;

    always_comb begin
        nxt_cmd   = CMD_START;
        nxt_wdata = 8'h00;
        case (state)
            S_DEVW:   begin nxt_cmd = CMD_WRITE; nxt_wdata = {dev_q, 1'b0}; end
            S_REG:    begin nxt_cmd = CMD_WRITE; nxt_wdata = reg_q; end
            S_DATA:   begin nxt_cmd = CMD_WRITE; nxt_wdata = wd_q; end
            S_RSTART: nxt_cmd = CMD_RSTART;
            S_DEVR:   begin nxt_cmd = CMD_WRITE; nxt_wdata = {dev_q, 1'b1}; end
            S_READ:   nxt_cmd = CMD_READ;
            S_STOP:   nxt_cmd = CMD_STOP;
            default:  nxt_cmd = CMD_START;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cur       <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= 8'h00;
            err       <= 2'd0;
            cmd_valid <= 1'b0;
            cmd       <= 3'd0;
            cmd_wdata <= 8'h00;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wd_q      <= 8'h00;
            retry     <= 3'd0;
            to_cnt    <= '0;
            err_lat   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        rw_q    <= req_rw;
                        dev_q   <= dev_addr;
                        reg_q   <= reg_addr;
                        wd_q    <= wr_data;
                        busy    <= 1'b1;
                        retry   <= 3'd0;
                        err_lat <= 2'd0;
                        state   <= S_START;
                    end
                end
                S_START, S_DEVW, S_REG, S_DATA, S_RSTART, S_DEVR, S_READ, S_STOP: begin
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                        cmd       <= nxt_cmd;
                        cmd_wdata <= nxt_wdata;
                    end else if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        to_cnt    <= '0;
                        cur       <= state;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        case (cur)
                            S_START:  state <= S_DEVW;
                            S_DEVW: begin
                                if (rsp_nack) begin
                                    err_lat <= 2'd1;
                                    state   <= S_STOP;
                                end else begin
                                    state <= S_REG;
                                end
                            end
                            S_REG: begin
                                if (rsp_nack) begin
                                    err_lat <= 2'd2;
                                    state   <= S_STOP;
                                end else begin
                                    state <= rw_q ? S_RSTART : S_DATA;
                                end
                            end
                            S_DATA: begin
                                if (rsp_nack) err_lat <= 2'd2;
                                state <= S_STOP;
                            end
                            S_RSTART: state <= S_DEVR;
                            S_DEVR: begin
                                if (rsp_nack) begin
                                    err_lat <= 2'd1;
                                    state   <= S_STOP;
                                end else begin
                                    state <= S_READ;
                                end
                            end
                            S_READ: begin
                                rd_data <= rsp_rdata;
                                state   <= S_STOP;
                            end
                            default: begin
                                if (err_lat != 2'd0 && retry < RETRY_MAX) begin
                                    retry   <= retry + 3'd1;
                                    err_lat <= 2'd0;
                                    state   <= S_START;
                                end else begin
                                    err   <= err_lat;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_DONE;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        // Core presumed hung: no STOP, no retry.
                        err   <= 2'd3;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: randomized core/slave behaviour checked against
// a transaction-level model of the expected command stream and results.
module tb_i2c_txn_sequencer;
    localparam int MAX_RETRY   = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int TO_W        = 5;

    logic       clk;
    logic       reset;
    logic       req;
    logic       req_rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic [1:0] err;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;

    i2c_txn_sequencer #(
        .MAX_RETRY  (MAX_RETRY),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_rw   (req_rw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .err      (err),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd      (cmd),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_nack (rsp_nack),
        .rsp_rdata(rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Commands are {cmd[2:0], byte}; byte is zero for anything but WRITE.
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic [7:0]  exp_rd;
    logic [1:0]  exp_err;

    function automatic void build_exp(input bit rw, input logic [6:0] dv, input logic [7:0] rg,
                                      input logic [7:0] wd, input logic [7:0] rdv,
                                      input int pol, input int nfail, input bit to_mode);
        logic [10:0] full[$];
        int nf;
        int fails;
        int w;
        bit cut;
        exp_q.delete();
        if (to_mode) begin
            exp_q.push_back({3'd0, 8'h00});
            exp_q.push_back({3'd1, dv, 1'b0});
            exp_err = 2'd3;
            return;
        end
        full.push_back({3'd0, 8'h00});
        full.push_back({3'd1, dv, 1'b0});
        full.push_back({3'd1, rg});
        if (rw) begin
            full.push_back({3'd4, 8'h00});
            full.push_back({3'd1, dv, 1'b1});
            full.push_back({3'd2, 8'h00});
        end else begin
            full.push_back({3'd1, wd});
        end
        full.push_back({3'd3, 8'h00});
        nf    = (pol == 0) ? 0 : nfail;
        fails = (nf > MAX_RETRY) ? MAX_RETRY + 1 : nf;
        // A NACKed attempt stops after the offending WRITE and closes with STOP.
        for (int a = 0; a < fails; a++) begin
            w   = 0;
            cut = 1'b0;
            for (int i = 0; i < full.size(); i++) begin
                if (!cut) begin
                    exp_q.push_back(full[i]);
                    if (full[i][10:8] == 3'd1) begin
                        w++;
                        if (w == pol) cut = 1'b1;
                    end
                end
            end
            exp_q.push_back({3'd3, 8'h00});
        end
        if (nf <= MAX_RETRY) begin
            for (int i = 0; i < full.size(); i++) exp_q.push_back(full[i]);
            exp_err = 2'd0;
            if (rw) exp_rd = rdv;
        end else begin
            exp_err = (pol == 1 || (pol == 3 && rw)) ? 2'd1 : 2'd2;
        end
    endfunction

    // pol: which WRITE of an attempt the slave NACKs (0 none); nfail: attempts that NACK.
    task automatic run_txn(input bit rw, input logic [6:0] dv, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rdv, input int pol,
                           input int nfail, input bit to_mode, input bit stall_reg, input bit rnd);
        int cyc, acc_cyc, done_cyc, pend, starts, widx, stall_left, nchk;
        bit pend_on, pend_nack, stalled, got_done, stall_used;
        logic [2:0]  pend_cmd;
        logic [10:0] held;
        build_exp(rw, dv, rg, wd, rdv, pol, nfail, to_mode);
        obs_q.delete();
        cyc = 0; acc_cyc = 0; done_cyc = 0; pend = 0; starts = 0; widx = 0; stall_left = 0;
        pend_on = 0; pend_nack = 0; stalled = 0; got_done = 0; stall_used = 0;
        pend_cmd = 3'd0; held = '0;
        @(negedge clk);
        req = 1'b1; req_rw = rw; dev_addr = dv; reg_addr = rg; wr_data = wd;
        @(negedge clk);
        cyc = 1;
        req = 1'b0; req_rw = 1'($urandom); dev_addr = 7'($urandom);
        reg_addr = 8'($urandom); wr_data = 8'($urandom);
        check_val("busy_rise", 32'(busy), 32'd1);
        check_val("cmd_not_yet", 32'(cmd_valid), 32'd0);
        cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!got_done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 6) req = 1'b0;
            if (cyc == 2) check_val("first_cmd_latency", 32'({cmd_valid, cmd}), 32'({1'b1, 3'd0}));
            if (stalled) check_val("stall_hold", 32'({cmd_valid, cmd, cmd_wdata}), 32'({1'b1, held}));
            rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'($urandom);
            if (done) begin
                got_done  = 1'b1;
                done_cyc  = cyc;
                cmd_ready = 1'b0;
            end else begin
                check_val("busy_hold", 32'(busy), 32'd1);
                if (rnd && cyc == 5) begin
                    req = 1'b1; req_rw = 1'($urandom); dev_addr = 7'($urandom);
                    reg_addr = 8'($urandom); wr_data = 8'($urandom);
                end
                if (pend_on) begin
                    if (pend == 0) begin
                        rsp_valid = 1'b1;
                        rsp_nack  = pend_nack;
                        if (pend_cmd == 3'd2) rsp_rdata = rdv;
                        pend_on = 1'b0;
                    end else begin
                        pend--;
                    end
                end else if (rnd && !to_mode && $urandom_range(0, 3) == 0) begin
                    rsp_valid = 1'b1;
                    rsp_nack  = 1'($urandom);
                end
                if (cmd_valid) begin
                    if (stall_left > 0) begin
                        cmd_ready = 1'b0;
                        stall_left--;
                    end else if (stall_reg && !stall_used && cmd == 3'd1 && widx == 1) begin
                        cmd_ready  = 1'b0;
                        stall_left = 4;
                        stall_used = 1'b1;
                    end else begin
                        cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    stalled = !cmd_ready;
                    held    = {cmd, cmd_wdata};
                    if (cmd_ready) begin
                        obs_q.push_back({cmd, (cmd == 3'd1) ? cmd_wdata : 8'h00});
                        if (cmd == 3'd0) begin
                            starts++;
                            widx = 0;
                        end
                        pend_cmd  = cmd;
                        pend_nack = 1'b0;
                        if (cmd == 3'd1) begin
                            widx++;
                            pend_nack = (pol != 0) && (starts - 1 < nfail) && (widx == pol);
                        end
                        pend    = rnd ? $urandom_range(0, 4) : 2;
                        pend_on = !(to_mode && cmd == 3'd1 && widx == 1);
                        if (to_mode && cmd == 3'd1 && widx == 1) acc_cyc = cyc;
                    end
                end else begin
                    stalled   = 1'b0;
                    cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
        if (!got_done) begin
            check_val("done_budget", 32'd0, 32'd1);
        end else begin
            check_val("done_busy_low", 32'(busy), 32'd0);
            check_val("err", 32'(err), 32'(exp_err));
            check_val("rd_data", 32'(rd_data), 32'(exp_rd));
            check_val("cmd_count", 32'(obs_q.size()), 32'(exp_q.size()));
            nchk = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
            for (int i = 0; i < nchk; i++)
                check_val($sformatf("cmd%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
            // Recorded at the negedge before the accepting edge, hence the +1.
            if (to_mode) check_val("timeout_latency", 32'(done_cyc - acc_cyc), 32'(TIMEOUT_CYC + 1));
            req = 1'b1; req_rw = 1'($urandom); dev_addr = 7'($urandom);
            @(negedge clk);
            check_val("done_pulse", 32'(done), 32'd0);
            check_val("req_in_done_ignored", 32'(busy), 32'd0);
            req = 1'b0;
            @(negedge clk);
            check_val("idle_after", 32'({busy, cmd_valid}), 32'd0);
        end
    endtask

    task automatic reset_mid_read();
        int seen;
        @(negedge clk);
        req = 1'b1; req_rw = 1'b1; dev_addr = 7'h50; reg_addr = 8'h22;
        @(negedge clk);
        req = 1'b0; cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_nack = 1'b0; rsp_rdata = 8'h99;
        repeat (2) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_rd_data", 32'(rd_data), 32'd0);
        check_val("arst_err", 32'(err), 32'd0);
        check_val("arst_cmd", 32'({cmd_valid, cmd, cmd_wdata}), 32'd0);
        exp_rd = 8'h00; exp_err = 2'd0;
        rsp_valid = 1'b0; cmd_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || cmd_valid) seen++;
        end
        check_val("no_start_after_reset", 32'(seen), 32'd0);
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; req_rw = 1'b0; dev_addr = '0; reg_addr = '0; wr_data = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = '0;
        exp_rd = 8'h00; exp_err = 2'd0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_rd_data", 32'(rd_data), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_cmd", 32'({cmd_valid, cmd, cmd_wdata}), 32'd0);
        reset = 1'b1;

        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h77, 1, 3, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 7'h50, 8'h10, 8'h5A, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0);
        run_txn(1'b0, 7'h50, 8'h10, 8'h5A, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0);
        run_txn(1'b0, 7'h2B, 8'h44, 8'hC3, 8'h00, 3, 2, 1'b0, 1'b0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            bit to_m;
            to_m = ($urandom_range(0, 7) == 0);
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    to_m ? 0 : $urandom_range(0, 3), $urandom_range(0, 3), to_m,
                    ($urandom_range(0, 3) == 0), 1'b1);
        end

        reset_mid_read();
        run_txn(1'b1, 7'h11, 8'h05, 8'h00, 8'hE7, 2, 1, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
